// File: rtl/mic_volume_meter.sv
// mic_volume_meter: windowed peak detector quantising mic amplitude to a 0-9 level with instant attack and stepped decay
// Ports: CLOCK/reset (sync, active-high); sample_valid+mic_in sample strobe;
//        volume_level 0-9 and level_valid pulse at each window end; peak_out last window peak.
module mic_volume_meter #(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int BASELINE       = 2048,
    parameter int STEP           = 200
) (
    input  logic        CLOCK,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [3:0]  volume_level,
    output logic        level_valid,
    output logic [11:0] peak_out
);
    localparam int CW = $clog2(WINDOW_SAMPLES);
    typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [11:0]   peak;
    logic [12:0]   amp;
    logic [3:0]    raw_level, raw_nx;
    logic          last;
    assign last = count == CW'(WINDOW_SAMPLES - 1);
    always_ff @(posedge CLOCK)
        state <= reset ? ACCUM : state_nx;
    always_comb begin
        state_nx = state == EVAL ? UPDATE :
                   state == UPDATE ? ACCUM :
                   (sample_valid && last) ? EVAL : ACCUM;
        // saturate below the DC offset so quiet input never wraps to a huge amplitude
        amp = peak > 12'(BASELINE) ? {1'b0, peak} - 13'(BASELINE) : 13'd0;
        raw_nx = 4'd0;
        for (int k = 1; k <= 9; k++)
            raw_nx = raw_nx + 4'(amp >= 13'(k * STEP));
    end
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            count        <= '0;
            peak         <= '0;
            raw_level    <= '0;
            volume_level <= '0;
            level_valid  <= 1'b0;
            peak_out     <= '0;
        end else begin
            level_valid <= state == UPDATE;
            if (state == ACCUM && sample_valid) begin
                peak  <= mic_in > peak ? mic_in : peak;
                count <= count + CW'(1);
            end
            if (state == EVAL) begin
                raw_level <= raw_nx;
                peak_out  <= peak;
            end
            if (state == UPDATE) begin
                volume_level <= raw_level >= volume_level ? raw_level : volume_level - 4'd1;
                peak         <= '0;
                count        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mic_volume_meter.sv
// tb_mic_volume_meter: directed checks of window peak, quantisation, attack/decay, reset and dropped samples
module tb_mic_volume_meter;
    logic        CLOCK = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = '0;
    logic [3:0]  volume_level;
    logic        level_valid;
    logic [11:0] peak_out;
    int checks = 0;
    int errors = 0;
    logic [3:0] cur_level = 4'd0;
    mic_volume_meter #(.WINDOW_SAMPLES(4), .BASELINE(2048), .STEP(200)) dut (
        .CLOCK(CLOCK),
        .reset(reset),
        .sample_valid(sample_valid),
        .mic_in(mic_in),
        .volume_level(volume_level),
        .level_valid(level_valid),
        .peak_out(peak_out)
    );
    always #5 CLOCK = ~CLOCK;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    // four samples, then EVAL and UPDATE cycles (optionally flooded with 4095 strobes), then one hold cycle
    task automatic run_window(input string tag, input logic [11:0] a, b, c, d,
                              input logic junk, input logic [3:0] el, input logic [11:0] ep);
        logic [11:0] s [4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            mic_in = s[i];
            @(negedge CLOCK);
        end
        sample_valid = junk;
        mic_in = 12'd4095;
        @(negedge CLOCK);
        check({tag, ".lv_early"}, level_valid, 0);
        check({tag, ".hold"}, volume_level, cur_level);
        @(negedge CLOCK);
        sample_valid = 1'b0;
        check({tag, ".lv"}, level_valid, 1);
        check({tag, ".level"}, volume_level, el);
        check({tag, ".peak"}, peak_out, ep);
        @(negedge CLOCK);
        check({tag, ".lv_pulse"}, level_valid, 0);
        check({tag, ".level_hold"}, volume_level, el);
        cur_level = el;
    endtask
    initial begin
        @(negedge CLOCK);
        @(negedge CLOCK);
        reset = 1'b0;
        check("rst.level", volume_level, 0);
        check("rst.lv", level_valid, 0);
        check("rst.peak", peak_out, 0);
        run_window("t1", 2048, 2100, 2000, 2048, 1'b0, 4'd0, 12'd2100);
        run_window("t2a", 2000, 2848, 2048, 2048, 1'b0, 4'd4, 12'd2848);
        run_window("t2b", 2048, 2048, 3848, 2048, 1'b0, 4'd9, 12'd3848);
        run_window("t2c", 4095, 2048, 2048, 2048, 1'b0, 4'd9, 12'd4095);
        for (int i = 0; i < 4; i++)
            run_window($sformatf("t3d%0d", i), 2048, 2048, 2048, 2048, 1'b0, 4'(8 - i), 12'd2048);
        run_window("t3e", 2048, 2448, 2048, 2048, 1'b0, 4'd4, 12'd2448);
        for (int i = 0; i < 4; i++)
            run_window($sformatf("t4d%0d", i), 1000, 900, 1000, 500, 1'b0, 4'(3 - i), 12'd1000);
        run_window("t4low", 1000, 1000, 1000, 1000, 1'b0, 4'd0, 12'd1000);
        run_window("t4b399", 2447, 2048, 2048, 2048, 1'b0, 4'd1, 12'd2447);
        run_window("t4b400", 2048, 2448, 2048, 2048, 1'b0, 4'd2, 12'd2448);
        run_window("t5up", 2048, 2048, 2048, 3248, 1'b0, 4'd6, 12'd3248);
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            mic_in = 12'd4095;
            @(negedge CLOCK);
        end
        sample_valid = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK);
        reset = 1'b0;
        check("t5.level", volume_level, 0);
        check("t5.lv", level_valid, 0);
        check("t5.peak", peak_out, 0);
        cur_level = 4'd0;
        run_window("t5fresh", 2100, 2048, 2048, 2048, 1'b0, 4'd0, 12'd2100);
        run_window("t6drop", 2048, 2200, 2048, 2048, 1'b1, 4'd0, 12'd2200);
        run_window("t6next", 2100, 2048, 2000, 2048, 1'b0, 4'd0, 12'd2100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_volume_meter.md
Name: mic_volume_meter

Overview:
- Converts the 12-bit microphone sample stream into a 0-9 volume level for the LED bar and 7-segment display stage.
- Sits directly upstream of that display stage.
- Tracks peak amplitude over a fixed window of valid samples and quantises it into 9 thresholds.
- Applies instant attack and one-step-per-window decay so the display rises fast and falls smoothly.

Parameters:
- WINDOW_SAMPLES, 4000, valid samples per measurement window (4000 = 0.2 s at 20 kHz); must be >= 2.
- BASELINE, 2048, mic DC offset subtracted from the peak.
- STEP, 200, amplitude per level; threshold k is k*STEP for k = 1..9; 9*STEP must be <= 4095-BASELINE.

Ports:
- CLOCK  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; mic_in is valid in the same cycle.
- mic_in  input  12  unsigned mic sample.
- volume_level  output  4  current level 0-9; feeds the display stage; registered.
- level_valid  output  1  one-cycle pulse when a window completes; volume_level is updated in the same cycle.
- peak_out  output  12  registered peak of the last completed window (debug).

Behaviour:
Reset:
- Synchronous reset applies on a CLOCK edge with reset=1.
- volume_level=0, level_valid=0, peak_out=0, internal peak=0, sample count=0, state=ACCUM.
- Reset overrides everything, including mid-window and mid-EVAL/UPDATE; the partial window is discarded.

FSM states: ACCUM, EVAL, UPDATE.
- ACCUM:
  - On sample_valid: peak <= max(peak, mic_in); count++.
  - When sample_valid arrives with count == WINDOW_SAMPLES-1, that sample is included in the peak, then state -> EVAL.
  - Without sample_valid, nothing changes.
- EVAL (1 cycle):
  - amp = peak - BASELINE if peak > BASELINE, else 0 (saturate; no wrap).
  - raw_level = number of k in 1..9 with amp >= k*STEP, range 0-9. Comparisons are done at 13 bits.
  - raw_level is registered. peak_out <= peak. State -> UPDATE.
- UPDATE (1 cycle):
  - If raw_level >= volume_level: volume_level <= raw_level (attack).
  - Else: volume_level <= volume_level - 1 (decay).
  - level_valid <= 1 for this cycle only. peak <= 0, count <= 0. State -> ACCUM.
- sample_valid asserted in EVAL or UPDATE is dropped: not counted and not peaked. At 20 kHz against 100 MHz this never occurs in system use, but it is defined behaviour.

Timing and ranges:
- Latency: level_valid rises 2 cycles after the CLOCK edge that accepts the final sample of a window.
- volume_level never exceeds 9 and never underflows below 0. Decay from 0 is not possible because raw_level >= 0 always selects attack.
- peak == BASELINE exactly gives amp=0 and level 0. amp == k*STEP exactly counts as reaching level k.
- mic_in=4095 gives amp=2047 and level 9 (saturates at 9).
- Between updates volume_level holds steady; it changes only in the level_valid cycle.

Test Plan:
1. Reset, then WINDOW_SAMPLES=4 with samples 2048,2100,2000,2048 -> amp=52, level_valid pulses 2 cycles after the 4th sample, volume_level=0, peak_out=2100.
2. Window containing peak 2848 (amp=800) -> volume_level=4. Next window with peak 3848 (amp=1800, exactly 9*STEP) -> 9. Window with mic_in=4095 -> stays 9.
3. From level 9, four consecutive windows with all samples 2048 -> volume_level steps 8,7,6,5, one decrement per level_valid. A window with peak 2448 (raw 2) arriving at level 5 -> 4 (decay, not jump).
4. Boundary: peak 2447 (amp 399) -> raw 1; peak 2448 (amp 400) -> raw 2; peak 1000 (below baseline) -> amp 0, raw 0.
5. Assert reset after 2 of 4 samples at level 6 -> all outputs 0 next cycle. The next window starts fresh, with no contribution from the pre-reset samples.
6. Drive sample_valid in the EVAL and UPDATE cycles with mic_in=4095 -> those samples are ignored. The next window's peak_out reflects only samples accepted in ACCUM.
